// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: time-multiplexed scan sequencer for a 4-digit FND driver.
// Holds a double-buffered 4-nibble BCD word. A loaded word is committed only
// at frame start, so a frame never tears. Each digit gets a dark gap
// (BLANK_CYC cycles) and then a lit slot (SHOW_CYC cycles).
// Optional feature macro: FND_LZ_BLANK_EN enables leading-zero blanking.
module fnd_scan_controller #(
  parameter int unsigned SHOW_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 8,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_EN,
  input  logic        i_load,
  input  logic [15:0] i_Value,
  output logic        o_EN,
  output logic [1:0]  o_DigitSelect,
  output logic [3:0]  o_Value,
  output logic        o_frame_done,
  output logic        o_pending
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       digit, digit_nx;
  logic [15:0]      display, display_nx;
  logic [15:0]      pend_buf, pend_buf_nx;
  logic             pending, pending_nx;
  logic             commit;
  logic             lit_nx;

  // Next-state computation; outputs are registered from these next values so
  // that every output is aligned with the state it describes.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CNT_W'(1);
    digit_nx    = digit;
    display_nx  = display;
    pend_buf_nx = pend_buf;
    pending_nx  = pending;
    commit      = 1'b0;

    if (!i_EN) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      digit_nx = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length gap skips BLANK entirely.
          state_nx = (BLANK_CYC == 0) ? SHOW : BLANK;
          cnt_nx   = '0;
          digit_nx = 2'd0;
          commit   = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nx = (BLANK_CYC == 0) ? SHOW : BLANK;
            cnt_nx   = '0;
            digit_nx = digit + 2'd1;
            commit   = (digit == 2'd3);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          digit_nx = 2'd0;
        end
      endcase
    end

    // Commit sees the buffer as it stood before this edge; a simultaneous
    // load then refills it and keeps pending set for the next frame.
    if (commit && pending) begin
      display_nx = pend_buf;
      pending_nx = 1'b0;
    end
    if (i_load) begin
      pend_buf_nx = i_Value;
      pending_nx  = 1'b1;
    end
  end

  // Leading-zero blanking decision for the digit about to be presented.
  always_comb begin
    lit_nx = 1'b1;
`ifdef FND_LZ_BLANK_EN
    case (digit_nx)
      2'd1:    lit_nx = |display_nx[15:4];
      2'd2:    lit_nx = |display_nx[15:8];
      2'd3:    lit_nx = |display_nx[15:12];
      default: lit_nx = 1'b1;
    endcase
`endif
  end

  // Sequencer state, buffers and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      digit         <= 2'd0;
      display       <= '0;
      pend_buf      <= '0;
      pending       <= 1'b0;
      o_EN          <= 1'b0;
      o_DigitSelect <= 2'd0;
      o_Value       <= 4'd0;
      o_frame_done  <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      digit         <= digit_nx;
      display       <= display_nx;
      pend_buf      <= pend_buf_nx;
      pending       <= pending_nx;
      o_EN          <= (state_nx == SHOW) && lit_nx;
      o_DigitSelect <= digit_nx;
      o_Value       <= display_nx[{digit_nx, 2'b00} +: 4];
      o_frame_done  <= (state_nx == SHOW) && (cnt_nx == SHOW_LAST) && (digit_nx == 2'd3);
    end
  end

  assign o_pending = pending;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: two instances (with and without a
// dark gap) driven by the same random stimulus; expected outputs come from a
// frame-position model and are checked by a separate monitor.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;

  typedef struct packed {
    logic       en;
    logic [1:0] dig;
    logic [3:0] val;
    logic       fd;
    logic       pend;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  obs_t  act_a, act_b;
  pair_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SHOW_CYC(4), .BLANK_CYC(1), .CNT_W(4)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_EN(en), .i_load(load), .i_Value(value),
    .o_EN(act_a.en), .o_DigitSelect(act_a.dig), .o_Value(act_a.val),
    .o_frame_done(act_a.fd), .o_pending(act_a.pend));

  fnd_scan_controller #(.SHOW_CYC(3), .BLANK_CYC(0), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_EN(en), .i_load(load), .i_Value(value),
    .o_EN(act_b.en), .o_DigitSelect(act_b.dig), .o_Value(act_b.val),
    .o_frame_done(act_b.fd), .o_pending(act_b.pend));

  // Reference model: per instance, position inside the frame since enable.
  int          m_show [2] = '{4, 3};
  int          m_blank[2] = '{1, 0};
  bit          m_active[2];
  int          m_t    [2];
  logic [15:0] m_disp [2];
  logic [15:0] m_buf  [2];
  bit          m_pend [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_t[i] = 0; m_disp[i] = '0; m_buf[i] = '0; m_pend[i] = 0;
    end
  endfunction

  function automatic void model_step(int i, logic e, logic l, logic [15:0] v);
    int  frame;
    bit  do_commit;
    frame     = 4 * (m_show[i] + m_blank[i]);
    do_commit = 0;
    if (!e) m_active[i] = 0;
    else if (!m_active[i]) begin
      m_active[i] = 1; m_t[i] = 0; do_commit = 1;
    end else begin
      m_t[i] = (m_t[i] + 1) % frame;
      do_commit = (m_t[i] == 0);
    end
    if (do_commit && m_pend[i]) begin
      m_disp[i] = m_buf[i]; m_pend[i] = 0;
    end
    if (l) begin
      m_buf[i] = v; m_pend[i] = 1;
    end
  endfunction

  function automatic obs_t model_obs(int i);
    obs_t o;
    int   slot, d;
    bit   lit;
    slot   = m_show[i] + m_blank[i];
    o.pend = m_pend[i];
    if (!m_active[i]) begin
      o.en = 0; o.dig = 0; o.fd = 0;
      o.val = m_disp[i][3:0];
      return o;
    end
    d   = m_t[i] / slot;
    lit = (m_t[i] % slot) >= m_blank[i];
`ifdef FND_LZ_BLANK_EN
    if (d != 0 && (m_disp[i] >> (4 * d)) == 16'd0) lit = 0;
`endif
    o.en  = lit;
    o.dig = 2'(d);
    o.val = 4'((m_disp[i] >> (4 * d)) & 16'hF);
    o.fd  = (m_t[i] == 4 * slot - 1);
    return o;
  endfunction

  task automatic drive(logic e, logic l, logic [15:0] v);
    pair_t p;
    @(negedge clk);
    en = e; load = l; value = v;
    @(posedge clk);
    model_step(0, e, l, v);
    model_step(1, e, l, v);
    p.a = model_obs(0);
    p.b = model_obs(1);
    exp_q.push_back(p);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0:       v = 16'($urandom);
      1:       v = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
      2:       v = 16'h0000;
      default: v = 16'h0070;
    endcase
    return v;
  endfunction

  // Monitor: checks reset values on every reset assertion, and pops one
  // expected entry per cycle otherwise.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        checks++;
        if (act_a !== '0 || act_b !== '0) begin
          errors++;
          $display("FAIL reset_outputs: got a=%b b=%b, expected all zero", act_a, act_b);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act_a !== e.a) begin
          errors++;
          $display("FAIL scan_a @%0t: got en=%b dig=%0d val=%h fd=%b pend=%b, expected en=%b dig=%0d val=%h fd=%b pend=%b",
                   $time, act_a.en, act_a.dig, act_a.val, act_a.fd, act_a.pend,
                   e.a.en, e.a.dig, e.a.val, e.a.fd, e.a.pend);
        end
        checks++;
        if (act_b !== e.b) begin
          errors++;
          $display("FAIL scan_b @%0t: got en=%b dig=%0d val=%h fd=%b pend=%b, expected en=%b dig=%0d val=%h fd=%b pend=%b",
                   $time, act_b.en, act_b.dig, act_b.val, act_b.fd, act_b.pend,
                   e.b.en, e.b.dig, e.b.val, e.b.fd, e.b.pend);
        end
      end
    end
  end

  // Stimulus: directed start-up, then random traffic with one mid-run reset.
  initial begin
    rst_n = 1'b1; en = 1'b0; load = 1'b0; value = '0;
    model_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 16'h5678);
    drive(1'b1, 1'b1, 16'h1111);
    drive(1'b1, 1'b1, 16'h2222);
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 16'h0070);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 16'h0);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(negedge clk);
        #2;
        en = 1'b0; load = 1'b0;
        exp_q.delete();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 6, rand_value());
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
